// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave register controller.
//   OPC_WRITE / OPC_READ : command opcodes carried in command byte bits [7:2]
//   state_e              : controller FSM states
package spi_slave_pkg;

    localparam int unsigned OPC_W  = 6;
    localparam int unsigned ADDR_W = 2;

    localparam logic [OPC_W-1:0] OPC_WRITE = 6'b110000;
    localparam logic [OPC_W-1:0] OPC_READ  = 6'b100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        IGNORE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave command decoder driving a 4-entry register file.
// A command byte (opcode[7:2], start addr[1:0]) selects a write burst, a read
// burst, or an ignored transaction; the start address auto-increments mod 4.
// Ports:
//   sclk, rst                 clock, async active-high reset
//   csn                       chip select (active-low), ends a transaction
//   rx_data, rx_valid         received byte strobe
//   tx_data, tx_valid, tx_ready  byte offered for transmission (READ only)
//   reg_wr_addr/data/valid    registered write port, 1 cycle after rx byte
//   reg_rd_addr, reg_rd_data  read port, address follows the burst pointer
//   cmd_error                 one-cycle pulse on an unrecognised opcode
module spi_slave_reg_ctrl
    import spi_slave_pkg::*;
#(
    parameter int unsigned REG_SIZE = 8
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                csn,
    input  logic [REG_SIZE-1:0] rx_data,
    input  logic                rx_valid,
    output logic [REG_SIZE-1:0] tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [ADDR_W-1:0]   reg_wr_addr,
    output logic [REG_SIZE-1:0] reg_wr_data,
    output logic                reg_wr_valid,
    output logic [ADDR_W-1:0]   reg_rd_addr,
    input  logic [REG_SIZE-1:0] reg_rd_data,
    output logic                cmd_error
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [REG_SIZE-1:0] wr_data_d;
    logic                cmd_error_d;
    logic [OPC_W-1:0]    opcode_c;

    assign opcode_c = rx_data[7:2];

    // State, burst pointer and registered write/error outputs
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            cmd_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            reg_wr_valid <= wr_valid_d;
            reg_wr_addr  <= wr_addr_d;
            reg_wr_data  <= wr_data_d;
            cmd_error    <= cmd_error_d;
        end
    end

    // Next-state and next-output decode; csn high wins over everything
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = reg_wr_addr;
        wr_data_d   = reg_wr_data;
        cmd_error_d = 1'b0;

        if (csn) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        addr_d = rx_data[ADDR_W-1:0];
                        if (opcode_c == OPC_WRITE) begin
                            state_d = WRITE;
                        end else if (opcode_c == OPC_READ) begin
                            state_d = READ;
                        end else begin
                            state_d     = IGNORE;
                            cmd_error_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_data;
                        addr_d     = addr_q + ADDR_W'(1);
                    end
                end
                READ: begin
                    // rx bytes here are full-duplex dummies and are dropped
                    if (tx_ready) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Read data is offered combinationally from the register file
    assign tx_valid    = (state_q == READ);
    assign tx_data     = tx_valid ? reg_rd_data : '0;
    assign reg_rd_addr = addr_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench for spi_slave_reg_ctrl with a write scoreboard.
module tb_spi_slave_reg_ctrl;

    logic       sclk;
    logic       rst;
    logic       csn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_valid;
    logic [1:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       cmd_error;

    logic [7:0] regs [4];

    typedef struct {
        int         due;
        logic [1:0] a;
        logic [7:0] d;
    } wr_exp_t;

    wr_exp_t    wq [$];
    logic [7:0] txq [$];
    wr_exp_t    we;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    spi_slave_reg_ctrl #(.REG_SIZE(8)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .csn          (csn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_valid (reg_wr_valid),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .cmd_error    (cmd_error)
    );

    assign reg_rd_data = regs[reg_rd_addr];

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= cyc + 1;

    // Write scoreboard: every strobe must match the oldest expected write and
    // appear exactly one cycle after its rx byte; nothing may go overdue.
    always @(negedge sclk) begin
        if (!rst) begin
            if (reg_wr_valid) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", reg_wr_addr, reg_wr_data, cyc);
                end else begin
                    we = wq.pop_front();
                    if (reg_wr_addr !== we.a || reg_wr_data !== we.d || cyc != we.due) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                                 reg_wr_addr, reg_wr_data, cyc, we.a, we.d, we.due);
                    end
                end
            end
            while (wq.size() > 0 && wq[0].due < cyc) begin
                checks++;
                errors++;
                we = wq.pop_front();
                $display("FAIL missing_write expected addr=%0d data=%h at cyc=%0d", we.a, we.d, we.due);
            end
        end
    end

    // One byte with a one-cycle rx_valid strobe; optionally expect a write
    task automatic send(input logic [7:0] b, input bit wr, input logic [1:0] a);
        @(negedge sclk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (wr) wq.push_back('{due: cyc + 1, a: a, d: b});
        @(negedge sclk);
        rx_valid = 1'b0;
    endtask

    task automatic end_txn();
        @(negedge sclk);
        csn = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (reg_wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid got %b expected 0", reg_wr_valid); end
        checks++; if (reg_wr_addr !== 2'd0) begin errors++; $display("FAIL rst_wr_addr got %0d expected 0", reg_wr_addr); end
        checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data got %h expected 00", reg_wr_data); end
        checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL rst_cmd_error got %b expected 0", cmd_error); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h expected 00", tx_data); end
        checks++; if (reg_rd_addr !== 2'd0) begin errors++; $display("FAIL rst_rd_addr got %0d expected 0", reg_rd_addr); end
        @(negedge sclk);
        @(negedge sclk);
        rst = 1'b0;
    endtask

    task automatic test_write_burst();
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC1, 1'b0, 2'd0);
        send(8'h10, 1'b1, 2'd1);
        send(8'h20, 1'b1, 2'd2);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL write_tx_idle got valid=%b data=%h expected 0/00", tx_valid, tx_data);
        end
        end_txn();
    endtask

    task automatic test_wrap();
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC3, 1'b0, 2'd0);
        send(8'hAA, 1'b1, 2'd3);
        send(8'hBB, 1'b1, 2'd0);
        end_txn();
    endtask

    // Unbounded burst with rx_valid on consecutive cycles
    task automatic test_back_to_back();
        logic [1:0] a;
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC2, 1'b0, 2'd0);
        a = 2'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge sclk);
            rx_data  = 8'h30 + 8'(i);
            rx_valid = 1'b1;
            wq.push_back('{due: cyc + 1, a: a, d: 8'h30 + 8'(i)});
            a = a + 2'd1;
        end
        @(negedge sclk);
        rx_valid = 1'b0;
        end_txn();
    endtask

    task automatic test_read();
        logic [7:0] exp;
        regs[0] = 8'h01; regs[1] = 8'h20; regs[2] = 8'h33; regs[3] = 8'h44;
        @(negedge sclk);
        csn      = 1'b0;
        tx_ready = 1'b0;
        send(8'h82, 1'b0, 2'd0);
        txq.push_back(8'h33);
        txq.push_back(8'h44);
        txq.push_back(8'h01);
        txq.push_back(8'h20);
        for (int i = 0; i < 4; i++) begin
            exp = txq.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                errors++;
                $display("FAIL read_beat%0d got valid=%b data=%h expected 1/%h", i, tx_valid, tx_data, exp);
            end
            // a dummy write-looking byte mid-burst must be ignored
            rx_valid = (i == 1);
            rx_data  = 8'hC0;
            tx_ready = (i < 3);
            @(negedge sclk);
        end
        rx_valid = 1'b0;
        checks++;
        if (reg_rd_addr !== 2'd1) begin
            errors++;
            $display("FAIL read_hold_addr got %0d expected 1", reg_rd_addr);
        end
        end_txn();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL read_end got valid=%b data=%h expected 0/00", tx_valid, tx_data);
        end
    endtask

    task automatic test_bad_opcode();
        int pulses;
        pulses = 0;
        @(negedge sclk);
        csn = 1'b0;
        send(8'h55, 1'b0, 2'd0);
        checks++;
        if (cmd_error !== 1'b1) begin errors++; $display("FAIL bad_op_pulse got %b expected 1", cmd_error); end
        @(negedge sclk);
        checks++;
        if (cmd_error !== 1'b0) begin errors++; $display("FAIL bad_op_one_cycle got %b expected 0", cmd_error); end
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            rx_valid = (i == 1);
            rx_data  = 8'hC0;
            if (cmd_error) pulses++;
        end
        rx_valid = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL ignore_no_error got %0d pulses expected 0", pulses); end
        end_txn();
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC0, 1'b0, 2'd0);
        send(8'h5A, 1'b1, 2'd0);
        end_txn();
    endtask

    task automatic test_abort();
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC2, 1'b0, 2'd0);
        @(negedge sclk);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        csn      = 1'b1;
        @(negedge sclk);
        rx_valid = 1'b0;
        checks++;
        if (reg_wr_valid !== 1'b0) begin errors++; $display("FAIL abort_no_write got %b expected 0", reg_wr_valid); end
        csn = 1'b0;
        send(8'h81, 1'b0, 2'd0);
        checks++;
        if (tx_valid !== 1'b1 || reg_rd_addr !== 2'd1) begin
            errors++;
            $display("FAIL abort_to_idle got valid=%b addr=%0d expected 1/1", tx_valid, reg_rd_addr);
        end
        end_txn();
        // strobe registered before csn rises still lands
        @(negedge sclk);
        csn = 1'b0;
        send(8'hC0, 1'b0, 2'd0);
        @(negedge sclk);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        wq.push_back('{due: cyc + 1, a: 2'd0, d: 8'h11});
        @(negedge sclk);
        rx_valid = 1'b0;
        csn      = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_reset_mid_read();
        @(negedge sclk);
        csn = 1'b0;
        send(8'h83, 1'b0, 2'd0);
        checks++;
        if (tx_valid !== 1'b1 || reg_rd_addr !== 2'd3 || tx_data !== 8'h44) begin
            errors++;
            $display("FAIL pre_rst_read got valid=%b addr=%0d data=%h expected 1/3/44", tx_valid, reg_rd_addr, tx_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || reg_rd_addr !== 2'd0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_rst got valid=%b addr=%0d data=%h expected 0/0/00", tx_valid, reg_rd_addr, tx_data);
        end
        @(negedge sclk);
        rst = 1'b0;
        send(8'hC1, 1'b0, 2'd0);
        send(8'h66, 1'b1, 2'd1);
        end_txn();
    endtask

    initial begin
        rst      = 1'b0;
        csn      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        #1 rst = 1'b1;
        test_reset();
        test_write_burst();
        test_wrap();
        test_back_to_back();
        test_read();
        test_bad_opcode();
        test_abort();
        test_reset_mid_read();
        repeat (4) @(negedge sclk);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL pending_writes got %0d expected 0", wq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
